// File: rtl/sprite_pkg.sv
// Sprite subsystem shared definitions.
// Holds the sprite ROM geometry and the reader FSM state encoding. The renderer
// imports this package too, so both sides agree on word and address widths.
package sprite_pkg;

    localparam int SPR_ADDR_W = 7;
    localparam int SPR_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_t;

endpackage

// File: rtl/sprite_rd_fifo.sv
// Return buffer for sprite_rom_reader: small synchronous FIFO with a
// fall-through head (head shows the oldest word whenever empty is low).
// Ports:
//   clk, reset      clock, asynchronous active-high reset (clears pointers/count)
//   push, push_data write one word
//   pop             remove the head word (ignored when empty)
//   head            oldest stored word
//   count           number of stored words (0..DEPTH)
//   empty           count == 0
// The reader's credit logic never pushes into a full FIFO, so no full flag is needed.
module sprite_rd_fifo
    import sprite_pkg::*;
#(
    parameter int DATA_W = SPR_DATA_W,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [CNT_W-1:0]  count,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              pop_ok_s;

    assign pop_ok_s = pop & (count_r != {CNT_W{1'b0}});

    // Storage array: data words need no reset, only the pointers do.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign empty = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/sprite_rom_reader.sv
// Avalon-MM read master that fetches a run of sprite words from the sprite ROM
// and presents them as a valid/ready stream to the sprite line logic.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   start, base_addr, word_count   run request (sampled only while idle)
//   busy, done                 run status; done pulses once per run
//   address, chipselect, read, byteenable, clken, readdata   Avalon master side
//   px_data, px_valid, px_ready, px_last                     stream side
// Reads are issued only while the return FIFO is guaranteed to have room for
// every word already requested, so readdata is never dropped.
module sprite_rom_reader
    import sprite_pkg::*;
#(
    parameter int ADDR_W     = SPR_ADDR_W,
    parameter int DATA_W     = SPR_DATA_W,
    parameter int CNT_W      = 8,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] address,
    output logic              chipselect,
    output logic              read,
    output logic [1:0]        byteenable,
    output logic              clken,
    input  logic [DATA_W-1:0] readdata,
    output logic [DATA_W-1:0] px_data,
    output logic              px_valid,
    input  logic              px_ready,
    output logic              px_last
);

    localparam int FC_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int OUT_W = FC_W + 1;

    rd_state_t         state_r, state_s;
    logic [ADDR_W-1:0] addr_q_r;
    logic [ADDR_W-1:0] address_r;
    logic [ADDR_W-1:0] issue_addr_s;
    logic [CNT_W-1:0]  issue_left_r;
    logic [CNT_W-1:0]  ret_left_r;
    logic              read_r;
    logic              busy_r;
    logic              done_r;
    logic [RD_LAT-1:0] strobe_r;
    logic              issue_s;
    logic              push_s;
    logic              pop_s;
    logic              drain_exit_s;
    logic              credit_ok_s;
    logic [OUT_W-1:0]  inflight_s;
    logic [FC_W-1:0]   fifo_count_s;
    logic              fifo_empty_s;
    logic [DATA_W-1:0] fifo_head_s;

    assign push_s = strobe_r[RD_LAT-1];
    assign pop_s  = px_valid & px_ready;

    // The read currently on the bus has not reached the strobe pipe yet, so it is
    // counted alongside the pipe; otherwise a back-to-back issue could overfill.
    always_comb begin
        inflight_s = OUT_W'(read_r);
        for (int i = 0; i < RD_LAT; i++) begin
            inflight_s = inflight_s + OUT_W'(strobe_r[i]);
        end
    end

    assign credit_ok_s = ((OUT_W'(fifo_count_s) + inflight_s) < OUT_W'(FIFO_DEPTH));

    // Run is finished once everything was returned, or the final word leaves now.
    assign drain_exit_s = ((ret_left_r == {CNT_W{1'b0}}) && fifo_empty_s) ||
                          (pop_s && (ret_left_r == CNT_W'(1)));

    // Next-state and read-issue decision.
    always_comb begin
        state_s      = state_r;
        issue_s      = 1'b0;
        issue_addr_s = addr_q_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    issue_addr_s = base_addr;
                    if (word_count != {CNT_W{1'b0}}) begin
                        issue_s = 1'b1;
                        state_s = FETCH;
                    end else begin
                        // Empty run: DRAIN exits at once, giving the same
                        // start-to-done bookkeeping path as a real run.
                        state_s = DRAIN;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: begin
                if (issue_left_r == {CNT_W{1'b0}}) begin
                    state_s = DRAIN;
                end else begin
                    issue_s = credit_ok_s;
                    state_s = FETCH;
                end
            end
            DRAIN: begin
                if (drain_exit_s) begin
                    state_s = DONE;
                end else begin
                    state_s = DRAIN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != IDLE);
            done_r  <= (state_r == DONE);
        end
    end

    // Avalon address/read strobe and the next address to request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_r    <= 1'b0;
            address_r <= {ADDR_W{1'b0}};
            addr_q_r  <= {ADDR_W{1'b0}};
        end else begin
            read_r <= issue_s;
            if (issue_s) begin
                address_r <= issue_addr_s;
                addr_q_r  <= issue_addr_s + ADDR_W'(1);
            end
        end
    end

    // Words still to request and words still to hand downstream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issue_left_r <= {CNT_W{1'b0}};
            ret_left_r   <= {CNT_W{1'b0}};
        end else begin
            if ((state_r == IDLE) && start) begin
                issue_left_r <= word_count - CNT_W'(issue_s);
                ret_left_r   <= word_count;
            end else begin
                if (issue_s) begin
                    issue_left_r <= issue_left_r - CNT_W'(1);
                end
                if (pop_s) begin
                    ret_left_r <= ret_left_r - CNT_W'(1);
                end
            end
        end
    end

    // Read-latency pipe: the last stage marks the cycle readdata is valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            strobe_r <= {RD_LAT{1'b0}};
        end else begin
            strobe_r[0] <= read_r;
            for (int i = 1; i < RD_LAT; i++) begin
                strobe_r[i] <= strobe_r[i-1];
            end
        end
    end

    sprite_rd_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH),
        .CNT_W  (FC_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (readdata),
        .pop       (pop_s),
        .head      (fifo_head_s),
        .count     (fifo_count_s),
        .empty     (fifo_empty_s)
    );

    assign busy       = busy_r;
    assign done       = done_r;
    assign address    = address_r;
    assign read       = read_r;
    assign chipselect = read_r;
    assign byteenable = 2'b11;
    assign clken      = 1'b1;
    assign px_valid   = ~fifo_empty_s;
    assign px_data    = fifo_head_s;
    assign px_last    = px_valid & (ret_left_r == CNT_W'(1));

endmodule
